// File: rtl/rotr_serial.sv
// Serial right-rotator: rotates in_data right by in_sh, one bit per clock.
// Ports: clk, rst (async high); in_data/in_sh/in_valid/in_ready request;
// out_q/out_valid/out_ready result; busy while not idle.
module rotr_serial #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_data,
  input  logic [SW-1:0] in_sh,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  data, data_nxt;
  logic [SW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      data  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      data  <= data_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          data_nxt  = in_data;
          cnt_nxt   = in_sh;
          state_nxt = (in_sh == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // One-bit right rotate per edge; leaving on the last step.
        data_nxt = {data[0], data[W-1:1]};
        cnt_nxt  = cnt - 1'b1;
        if (cnt == SW'(1))
          state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign out_q = data;

endmodule

// File: tb/tb_rotr_serial.sv
// Self-checking bench for rotr_serial: transaction-level timing model,
// directed literal cases, exhaustive round trip and random traffic.
module tb_rotr_serial;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic [2:0] in_sh;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_q;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int ncmp;
  int nbad;

  rotr_serial #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sh     (in_sh),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_q     (out_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ror8(input logic [7:0] x, input int n);
    logic [15:0] y;
    y = {x, x} >> n;
    return y[7:0];
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
    logic [15:0] y;
    y = {x, x} << n;
    return y[15:8];
  endfunction

  // Transaction model: a request accepted at cycle c with amount n
  // becomes visible after cycle c+n and is retired by a handshake.
  bit         m_idle;
  bit         m_valid;
  bit         m_pend;
  logic [7:0] m_res;
  int         cyc;
  int         m_due;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle  = 1'b1;
      m_valid = 1'b0;
      m_pend  = 1'b0;
      m_res   = 8'h00;
    end else begin
      cyc = cyc + 1;
      if (m_idle && in_valid) begin
        m_res  = ror8(in_data, int'(in_sh));
        m_due  = cyc + int'(in_sh);
        m_idle = 1'b0;
        m_pend = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
        m_idle  = 1'b1;
      end
      if (m_pend && cyc >= m_due) begin
        m_pend  = 1'b0;
        m_valid = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic cmp_model();
    chk("m_in_ready", 32'(in_ready), 32'(m_idle));
    chk("m_busy", 32'(busy), 32'(!m_idle));
    chk("m_out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid)
      chk("m_out_q", 32'(out_q), 32'(m_res));
  endtask

  // One cycle: model compare at negedge, then land 2 units after posedge.
  task automatic step();
    @(negedge clk);
    cmp_model();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (!in_ready && g < 40) begin
      step();
      g++;
    end
    chk("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic run_one(input logic [7:0] x, input int n,
                         input logic [7:0] exp);
    int lat;
    wait_idle();
    in_data   = x;
    in_sh     = 3'(n);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'(n));
    chk("result", 32'(out_q), 32'(exp));
    step();
  endtask

  initial begin
    ncmp      = 0;
    nbad      = 0;
    cyc       = 0;
    rst       = 1'b0;
    in_data   = 8'h00;
    in_sh     = 3'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_q", 32'(out_q), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Basic, zero and max shift
    run_one(8'hB4, 3, 8'h96);
    chk("basic_in_ready", 32'(in_ready), 32'd1);
    run_one(8'hA5, 0, 8'hA5);

    wait_idle();
    in_data  = 8'h01;
    in_sh    = 3'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("max_busy", 32'(busy), 32'd1);
      chk("max_early", 32'(out_valid), 32'd0);
      step();
    end
    chk("max_busy", 32'(busy), 32'd1);
    chk("max_valid", 32'(out_valid), 32'd1);
    chk("max_q", 32'(out_q), 32'h02);
    step();
    chk("max_ret_busy", 32'(busy), 32'd0);
    chk("max_ret_ready", 32'(in_ready), 32'd1);

    // Backpressure with a second request held on in_valid
    out_ready = 1'b0;
    in_data   = 8'h3C;
    in_sh     = 3'd2;
    in_valid  = 1'b1;
    step();
    in_data = 8'h55;
    in_sh   = 3'd1;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_q", 32'(out_q), 32'h0F);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("bp_2nd_busy", 32'(busy), 32'd1);
    step();
    chk("bp_2nd_valid", 32'(out_valid), 32'd1);
    chk("bp_2nd_q", 32'(out_q), 32'hAA);
    step();

    // Reset in the middle of a shift
    wait_idle();
    in_data  = 8'hC3;
    in_sh    = 3'd6;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_q", 32'(out_q), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      step();
    end
    rst = 1'b1;
    step();
    // First edge after release must accept
    rst      = 1'b0;
    in_data  = 8'h77;
    in_sh    = 3'd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("first_acc_valid", 32'(out_valid), 32'd1);
    chk("first_acc_q", 32'(out_q), 32'h77);
    step();

    // Exhaustive round trip
    for (int x = 0; x < 256; x++)
      for (int n = 0; n < 8; n++)
        run_one(rol8(8'(x), n), n, 8'(x));

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      in_sh     = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
